cpa_accumulator: RTL and testbench

- Downstream consumer of the compressor42 carry-save pair: resolves sum/carry vectors with a carry-propagate add, then accumulates the results over a group of beats.
- Emits one accumulated result per group.
- Two-stage pipeline: CPA register, then accumulator/output register.
- valid/ready handshakes on both sides, with full backpressure.

---
 rtl/cpa_accumulator_pkg.sv | 21 ++
 rtl/cpa_add.sv | 13 +
 rtl/cpa_accumulator.sv | 106 ++++++++++
 tb/tb_cpa_accumulator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpa_accumulator_pkg.sv
// rtl/cpa_accumulator_pkg.sv - shared widths and carry-save beat bundle for the CPA accumulator
package cpa_accumulator_pkg;

  // Default compressor operand width used across the datapath.
  localparam int NN_DEF = 16;

  // Carry-save vector width coming out of the compressor tree.
  localparam int CS_W = NN_DEF + 1;

  // Resolved sum width: two CS_W vectors added without truncation.
  localparam int CPA_W = NN_DEF + 2;

  // One carry-save beat as produced by the compressor tree's output stage.
  typedef struct packed {
    logic [CS_W-1:0] sum;
    logic [CS_W-1:0] carry;
    logic            first;
    logic            last;
  } cs_beat_t;

endpackage

// File: rtl/cpa_add.sv
// rtl/cpa_add.sv - carry-propagate adder resolving a carry-save pair
module cpa_add #(
  parameter int NN = 16
) (
  input  logic [NN:0]   i_a,
  input  logic [NN:0]   i_b,
  output logic [NN+1:0] o_s
);

  // Ripple form for now; both operands are zero-extended so the carry out lands in the top bit.
  assign o_s = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/cpa_accumulator.sv
// rtl/cpa_accumulator.sv - resolves carry-save beats and accumulates them into one result per group
module cpa_accumulator
  import cpa_accumulator_pkg::*;
#(
  parameter int NN = NN_DEF,
  parameter int AW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NN:0]   in_sum,
  input  logic [NN:0]   in_carry,
  input  logic          in_first,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_ovf
);

  // Zero padding that lifts a resolved beat to the AW+1 accumulation width.
  localparam int PAD_W = AW - NN - 1;

  logic            w_en;
  logic [NN+1:0]   w_cpa;
  logic [AW:0]     w_beat_ext;
  logic [AW:0]     w_nxt;
  logic            w_novf;

  logic            r_s1_valid;
  logic            r_s1_first;
  logic            r_s1_last;
  logic [NN+1:0]   r_s1_sum;

  logic [AW-1:0]   r_acc;
  logic            r_ovf;

  logic            r_out_valid;
  logic [AW-1:0]   r_out_acc;
  logic            r_out_ovf;

  // The whole pipeline advances together; it only stalls when a result is held and not taken.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  cpa_add #(
    .NN (NN)
  ) u_cpa_add (
    .i_a (in_sum),
    .i_b (in_carry),
    .o_s (w_cpa)
  );

  // A first beat reloads the accumulator; the extra top bit catches the wrap out of AW bits.
  assign w_beat_ext = {{PAD_W{1'b0}}, r_s1_sum};
  assign w_nxt      = r_s1_first ? w_beat_ext : ({1'b0, r_acc} + w_beat_ext);
  assign w_novf     = (r_s1_first ? 1'b0 : r_ovf) | w_nxt[AW];

  // Stage 1: register the resolved sum and the group markers of an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sum   <= w_cpa;
      if (in_valid) begin
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end
    end
  end

  // Stage 2: fold the beat into the running group, or close the group into the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      if (r_s1_valid && r_s1_last) begin
        r_out_acc   <= w_nxt[AW-1:0];
        r_out_ovf   <= w_novf;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_ovf       <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
        if (r_s1_valid) begin
          r_acc <= w_nxt[AW-1:0];
          r_ovf <= w_novf;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_cpa_accumulator.sv
// tb/tb_cpa_accumulator.sv - scoreboard bench for cpa_accumulator at AW=40 and AW=18
module tb_cpa_accumulator;
  import cpa_accumulator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid;
  logic            in_first;
  logic            in_last;
  logic [CS_W-1:0] in_sum;
  logic [CS_W-1:0] in_carry;
  logic            out_ready;

  logic            in_ready_a, in_ready_b;
  logic            out_valid_a, out_valid_b;
  logic            out_ovf_a, out_ovf_b;
  logic [39:0]     out_acc_a;
  logic [17:0]     out_acc_b;

  cpa_accumulator #(.NN(16), .AW(40)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_acc   (out_acc_a),
    .out_ovf   (out_ovf_a)
  );

  cpa_accumulator #(.NN(16), .AW(18)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_acc   (out_acc_b),
    .out_ovf   (out_ovf_b)
  );

  typedef struct {
    logic [39:0] acc_a;
    logic        ovf_a;
    logic [17:0] acc_b;
    logic        ovf_b;
    int          t;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          total_n = 0;
  int          bad_n   = 0;
  int          cyc     = 0;
  logic [63:0] grp     = '0;
  logic [63:0] v;
  bit          chk_lat    = 1'b0;
  bit          rand_ready = 1'b0;
  bit          stalled    = 1'b0;
  logic [39:0] hold_a;
  logic [17:0] hold_b;
  cs_beat_t    beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_n++;
    if (act !== req) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and reference model: results are checked against the queue, accepted beats feed the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", in_ready_a, !out_valid_a || out_ready);
      check("in_ready_b", in_ready_b, in_ready_a);
      check("out_valid_b", out_valid_b, out_valid_a);
      if (stalled) begin
        check("stall_valid", out_valid_a, 1);
        check("stall_acc_a", out_acc_a, hold_a);
        check("stall_acc_b", out_acc_b, hold_b);
      end
      if (out_valid_a && out_ready) begin
        if (q.size() == 0) begin
          total_n++;
          bad_n++;
          $display("FAIL unexpected_out: got acc %0h want no result (cycle %0d)", out_acc_a, cyc);
        end else begin
          e = q.pop_front();
          check("acc_a", out_acc_a, e.acc_a);
          check("ovf_a", out_ovf_a, e.ovf_a);
          check("acc_b", out_acc_b, e.acc_b);
          check("ovf_b", out_ovf_b, e.ovf_b);
          if (chk_lat) check("latency", cyc - e.t, 2);
        end
      end
      stalled = out_valid_a && !out_ready;
      hold_a  = out_acc_a;
      hold_b  = out_acc_b;
      if (in_valid && in_ready_a) begin
        v   = 64'(in_sum) + 64'(in_carry);
        grp = in_first ? v : grp + v;
        if (in_last) begin
          e.acc_a = grp[39:0];
          e.ovf_a = (grp >> 40) != 0;
          e.acc_b = grp[17:0];
          e.ovf_b = (grp >> 18) != 0;
          e.t     = cyc;
          q.push_back(e);
          grp = '0;
        end
      end
    end else begin
      q.delete();
      grp     = '0;
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [16:0] s, input logic [16:0] c, input logic f, input logic l);
    int n;
    beat = '{sum: s, carry: c, first: f, last: l};
    in_valid = 1'b1;
    in_sum   = beat.sum;
    in_carry = beat.carry;
    in_first = beat.first;
    in_last  = beat.last;
    n = 0;
    @(negedge clk);
    while (!in_ready_a) begin
      n++;
      if (n > 300) begin
        total_n++;
        bad_n++;
        $display("FAIL accept_timeout: got in_ready 0 for %0d cycles want 1", n);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(2);
    check("drained", q.size(), 0);
  endtask

  initial begin
    #2000000;
    bad_n++;
    $display("FAIL global_timeout: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_valid", out_valid_a, 0);
    check("rst_acc_a", out_acc_a, 0);
    check("rst_ovf_a", out_ovf_a, 0);
    check("rst_acc_b", out_acc_b, 0);
    check("rst_ready", in_ready_a, 1);
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    send(17'h00010, 17'h00022, 1'b1, 1'b1);
    idle(4);

    for (int i = 0; i < 4; i++) send(17'h1FFFF, 17'h00001, i == 0, i == 3);
    idle(4);

    send(17'h1FFF8, 17'h1FFF8, 1'b1, 1'b0);
    send(17'h00010, 17'h00010, 1'b0, 1'b1);
    send(17'h00001, 17'h00000, 1'b1, 1'b1);
    idle(4);

    send(17'h00100, 17'h00002, 1'b1, 1'b0);
    send(17'h00300, 17'h00004, 1'b0, 1'b0);
    do_reset();
    send(17'h00003, 17'h00002, 1'b1, 1'b1);
    idle(4);

    send(17'h00001, 17'h00000, 1'b1, 1'b1);
    idle(1);
    send(17'h00000, 17'h00002, 1'b1, 1'b1);
    idle(2);
    send(17'h00001, 17'h00002, 1'b1, 1'b1);
    send(17'h00004, 17'h00000, 1'b0, 1'b1);
    drain();
    chk_lat = 1'b0;

    out_ready = 1'b0;
    fork
      begin
        send(17'h00007, 17'h00000, 1'b1, 1'b1);
        send(17'h00001, 17'h00000, 1'b1, 1'b0);
        send(17'h00002, 17'h00000, 1'b0, 1'b1);
        send(17'h00009, 17'h00000, 1'b1, 1'b1);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(17'($urandom_range(0, 17'h1FFFF)), 17'($urandom_range(0, 17'h1FFFF)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    send(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
